// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the EX stage, producing HI/LO.
// Optional multiply early-out is enabled by defining MULDIV_EARLY_OUT_EN.
module ex_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             dbz_o
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_lo;
    logic             r_neg_res;
    logic             r_neg_rem;
    logic             r_dbz_pend;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_hi_out;
    logic [WIDTH-1:0] r_lo_out;
    logic             r_dbz;

    logic             w_s1neg;
    logic             w_s2neg;
    logic [WIDTH-1:0] w_mag1;
    logic [WIDTH-1:0] w_mag2;
    logic             w_div0;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_mul_acc;
    logic [WIDTH-1:0] w_mul_lo;
    logic [WIDTH:0]   w_rem_sh;
    logic             w_ge;
    logic [WIDTH-1:0] w_div_acc;
    logic [WIDTH-1:0] w_div_lo;
    logic [WIDTH-1:0] w_nxt_acc;
    logic [WIDTH-1:0] w_nxt_lo;
    logic             w_last;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_neg;

    // Operand sign handling: magnitudes feed the unsigned datapath.
    assign w_s1neg = op_i[0] & src1_i[WIDTH-1];
    assign w_s2neg = op_i[0] & src2_i[WIDTH-1];
    assign w_mag1  = w_s1neg ? ('0 - src1_i) : src1_i;
    assign w_mag2  = w_s2neg ? ('0 - src2_i) : src2_i;
    assign w_div0  = op_i[1] && (src2_i == '0);

    // Shift-add multiply step: multiplier lives in r_lo, product shifts in.
    assign w_sum     = {1'b0, r_acc} + (r_lo[0] ? {1'b0, r_dvs} : '0);
    assign w_mul_acc = w_sum[WIDTH:1];
    assign w_mul_lo  = {w_sum[0], r_lo[WIDTH-1:1]};

    // Restoring divide step: dividend shifts out of r_lo, quotient shifts in.
    assign w_rem_sh  = {r_acc, r_lo[WIDTH-1]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_dvs});
    assign w_div_acc = w_ge ? (w_rem_sh[WIDTH-1:0] - r_dvs)
                            : w_rem_sh[WIDTH-1:0];
    assign w_div_lo  = {r_lo[WIDTH-2:0], w_ge};

    assign w_nxt_acc = r_op[1] ? w_div_acc : w_mul_acc;
    assign w_nxt_lo  = r_op[1] ? w_div_lo  : w_mul_lo;
    assign w_last    = (r_cnt == CNT_W'(WIDTH-1));

    assign w_prod     = {r_acc, r_lo};
    assign w_prod_neg = '0 - w_prod;

`ifdef MULDIV_EARLY_OUT_EN
    logic               r_eo;
    logic [CNT_W-1:0]   w_cnt1;
    logic [WIDTH-1:0]   w_rest_mask;
    logic               w_eo_hit;
    logic [CNT_W-1:0]   w_shamt;
    logic [2*WIDTH-1:0] w_aligned;

    // Multiplier bits not yet consumed after this step all zero -> finish now.
    assign w_cnt1      = r_cnt + CNT_W'(1);
    assign w_rest_mask = {WIDTH{1'b1}} >> w_cnt1;
    assign w_eo_hit    = !r_op[1] && !w_last &&
                         ((w_mul_lo & w_rest_mask) == '0);
    assign w_shamt     = CNT_W'(WIDTH-1) - r_cnt;
    assign w_aligned   = {w_mul_acc, w_mul_lo} >> w_shamt;
`endif

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_op       <= '0;
            r_dvs      <= '0;
            r_acc      <= '0;
            r_lo       <= '0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_dbz_pend <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_hi_out   <= '0;
            r_lo_out   <= '0;
            r_dbz      <= 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
            r_eo       <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_busy    <= 1'b1;
                        r_dbz     <= 1'b0;
                        r_op      <= op_i;
                        r_cnt     <= '0;
                        r_neg_res <= w_s1neg ^ w_s2neg;
                        r_neg_rem <= w_s1neg;
                        if (w_div0) begin
                            r_acc      <= src1_i;
                            r_dbz_pend <= 1'b1;
                            r_state    <= S_FIX;
                        end else begin
                            r_acc      <= '0;
                            r_dbz_pend <= 1'b0;
                            r_lo  <= op_i[1] ? w_mag1 : w_mag2;
                            r_dvs <= op_i[1] ? w_mag2 : w_mag1;
                            r_state    <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
`ifdef MULDIV_EARLY_OUT_EN
                    if (r_eo) begin
                        r_state <= S_FIX;
                    end else if (w_eo_hit) begin
                        {r_acc, r_lo} <= w_aligned;
                        r_eo <= 1'b1;
                    end else begin
                        r_acc <= w_nxt_acc;
                        r_lo  <= w_nxt_lo;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_last) r_state <= S_FIX;
                    end
`else
                    r_acc <= w_nxt_acc;
                    r_lo  <= w_nxt_lo;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) r_state <= S_FIX;
`endif
                end
                S_FIX: begin
                    if (r_dbz_pend) begin
                        r_hi_out <= r_acc;
                        r_lo_out <= '1;
                        r_dbz    <= 1'b1;
                    end else if (r_op[1]) begin
                        r_hi_out <= r_neg_rem ? ('0 - r_acc) : r_acc;
                        r_lo_out <= r_neg_res ? ('0 - r_lo) : r_lo;
                    end else begin
                        {r_hi_out, r_lo_out} <= r_neg_res ? w_prod_neg
                                                          : w_prod;
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
`ifdef MULDIV_EARLY_OUT_EN
                    r_eo    <= 1'b0;
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy_o = r_busy;
    assign done_o = r_done;
    assign hi_o   = r_hi_out;
    assign lo_o   = r_lo_out;
    assign dbz_o  = r_dbz;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed testbench for ex_muldiv_unit.
// Early-out expectations follow MULDIV_EARLY_OUT_EN when defined.
module tb_ex_muldiv_unit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] src1_i = '0;
    logic [31:0] src2_i = '0;
    logic        busy_o;
    logic        done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        dbz_o;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] MULTU = 2'b00;
    localparam logic [1:0] MULT  = 2'b01;
    localparam logic [1:0] DIVU  = 2'b10;
    localparam logic [1:0] DIV   = 2'b11;

    ex_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .op_i    (op_i),
        .src1_i  (src1_i),
        .src2_i  (src2_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .hi_o    (hi_o),
        .lo_o    (lo_o),
        .dbz_o   (dbz_o)
    );

    always #5 clk_i = ~clk_i;

    // Launch one op, return edges until done (-1 on timeout) and busy count.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int lat,
                          output int bcnt);
        start_i = 1'b1;
        op_i    = op;
        src1_i  = a;
        src2_i  = b;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        src1_i  = $urandom;
        src2_i  = $urandom;
        lat  = 0;
        bcnt = 0;
        while (!done_o && lat < 100) begin
            if (busy_o) bcnt++;
            @(posedge clk_i); #1;
            lat++;
        end
        if (!done_o) lat = -1;
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        checks++;
        if ({busy_o, done_o, dbz_o, hi_o, lo_o} !== '0) begin
            errors++;
            $display("FAIL reset_state got b%b d%b z%b %h %h exp all 0",
                     busy_o, done_o, dbz_o, hi_o, lo_o);
        end
    endtask

    task automatic test_multu_max;
        int lat, bcnt;
        run_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bcnt);
        checks++;
        if (lat !== 33) begin
            errors++;
            $display("FAIL multu_latency got %0d exp 33", lat);
        end
        checks++;
        if (bcnt !== 33) begin
            errors++;
            $display("FAIL multu_busy got %0d exp 33", bcnt);
        end
        checks++;
        if ({hi_o, lo_o} !== 64'hFFFFFFFE_00000001) begin
            errors++;
            $display("FAIL multu_max got %h%h exp fffffffe00000001",
                     hi_o, lo_o);
        end
        checks++;
        if (busy_o !== 1'b0 || dbz_o !== 1'b0) begin
            errors++;
            $display("FAIL multu_flags got b%b z%b exp b0 z0", busy_o, dbz_o);
        end
    endtask

    task automatic test_signed;
        int lat, bcnt;
        run_op(MULT, 32'hFFFFFFF9, 32'h00000006, lat, bcnt);
        checks++;
        if (lat !== 33 || {hi_o, lo_o} !== 64'hFFFFFFFF_FFFFFFD6) begin
            errors++;
            $display("FAIL mult_neg got %0d %h%h exp 33 ffffffffffffffd6",
                     lat, hi_o, lo_o);
        end
        run_op(DIV, 32'hFFFFFFF9, 32'h00000002, lat, bcnt);
        checks++;
        if (lat !== 33 || lo_o !== 32'hFFFFFFFD || hi_o !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL div_neg got %0d lo %h hi %h exp 33 fffffffd ffffffff",
                     lat, lo_o, hi_o);
        end
    endtask

    task automatic test_div;
        int lat, bcnt;
        run_op(DIVU, 32'd100, 32'd7, lat, bcnt);
        checks++;
        if (lat !== 33 || lo_o !== 32'd14 || hi_o !== 32'd2) begin
            errors++;
            $display("FAIL divu_100_7 got %0d lo %0d hi %0d exp 33 14 2",
                     lat, lo_o, hi_o);
        end
        run_op(DIV, 32'h80000000, 32'hFFFFFFFF, lat, bcnt);
        checks++;
        if (lo_o !== 32'h80000000 || hi_o !== 32'h0 || dbz_o !== 1'b0) begin
            errors++;
            $display("FAIL div_ovf got lo %h hi %h z%b exp 80000000 0 0",
                     lo_o, hi_o, dbz_o);
        end
    endtask

    task automatic test_dbz;
        int lat, bcnt;
        run_op(DIVU, 32'd5, 32'd0, lat, bcnt);
        checks++;
        if (lat !== 1 || bcnt !== 1) begin
            errors++;
            $display("FAIL dbz_latency got %0d busy %0d exp 1 1", lat, bcnt);
        end
        checks++;
        if (hi_o !== 32'd5 || lo_o !== 32'hFFFFFFFF || dbz_o !== 1'b1) begin
            errors++;
            $display("FAIL dbz_result got hi %h lo %h z%b exp 5 ffffffff 1",
                     hi_o, lo_o, dbz_o);
        end
        run_op(MULTU, 32'd3, 32'd4, lat, bcnt);
        checks++;
        if (dbz_o !== 1'b0 || lo_o !== 32'd12 || hi_o !== 32'd0) begin
            errors++;
            $display("FAIL dbz_clear got z%b lo %0d hi %0d exp 0 12 0",
                     dbz_o, lo_o, hi_o);
        end
        run_op(DIV, 32'hFFFFFFF9, 32'd0, lat, bcnt);
        checks++;
        if (hi_o !== 32'hFFFFFFF9 || lo_o !== 32'hFFFFFFFF || dbz_o !== 1'b1) begin
            errors++;
            $display("FAIL dbz_signed got hi %h lo %h z%b exp fffffff9 ffffffff 1",
                     hi_o, lo_o, dbz_o);
        end
    endtask

    task automatic test_ignored_start;
        int lat;
        start_i = 1'b1;
        op_i    = MULTU;
        src1_i  = 32'd2;
        src2_i  = 32'd3;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        lat = 0;
        repeat (9) begin
            @(posedge clk_i); #1;
            lat++;
        end
        start_i = 1'b1;
        op_i    = DIVU;
        src1_i  = 32'd77;
        src2_i  = 32'd5;
        @(posedge clk_i); #1;
        lat++;
        start_i = 1'b0;
        while (!done_o && lat < 100) begin
            @(posedge clk_i); #1;
            lat++;
        end
        checks++;
        if (lat !== 33 || lo_o !== 32'd6 || hi_o !== 32'd0) begin
            errors++;
            $display("FAIL ignored_start got %0d lo %0d hi %0d exp 33 6 0",
                     lat, lo_o, hi_o);
        end
    endtask

    task automatic test_back_to_back;
        int lat, bcnt;
        run_op(DIVU, 32'd1000, 32'd10, lat, bcnt);
        checks++;
        if (done_o !== 1'b1 || lo_o !== 32'd100) begin
            errors++;
            $display("FAIL b2b_first got d%b lo %0d exp 1 100", done_o, lo_o);
        end
        run_op(MULTU, 32'd7, 32'd8, lat, bcnt);
        checks++;
        if (lat !== 33 || lo_o !== 32'd56) begin
            errors++;
            $display("FAIL b2b_second got %0d lo %0d exp 33 56", lat, lo_o);
        end
        src1_i = 32'h12345678;
        src2_i = 32'h9ABCDEF0;
        repeat (5) @(posedge clk_i);
        #1;
        checks++;
        if (lo_o !== 32'd56 || hi_o !== 32'd0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL hold got lo %0d hi %0d d%b exp 56 0 0",
                     lo_o, hi_o, done_o);
        end
    endtask

    task automatic test_reset_mid;
        bit seen;
        start_i = 1'b1;
        op_i    = DIVU;
        src1_i  = 32'd1000;
        src2_i  = 32'd3;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (14) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid got b%b hi %h lo %h exp 0 0 0",
                     busy_o, hi_o, lo_o);
        end
        seen = 1'b0;
        repeat (40) begin
            if (done_o) seen = 1'b1;
            @(posedge clk_i); #1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done got %b exp 0", seen);
        end
    endtask

    task automatic test_early_out;
        int lat, bcnt;
        run_op(MULTU, 32'd9, 32'd1, lat, bcnt);
`ifdef MULDIV_EARLY_OUT_EN
        checks++;
        if (lat < 1 || lat > 3 || lo_o !== 32'd9) begin
            errors++;
            $display("FAIL early_out got %0d lo %0d exp <=3 9", lat, lo_o);
        end
`else
        checks++;
        if (lat !== 33 || lo_o !== 32'd9) begin
            errors++;
            $display("FAIL mul_fixed got %0d lo %0d exp 33 9", lat, lo_o);
        end
`endif
        run_op(DIVU, 32'd9, 32'd1, lat, bcnt);
        checks++;
        if (lat !== 33 || lo_o !== 32'd9 || hi_o !== 32'd0) begin
            errors++;
            $display("FAIL div_fixed got %0d lo %0d hi %0d exp 33 9 0",
                     lat, lo_o, hi_o);
        end
    endtask

    initial begin
        test_reset;
        test_multu_max;
        test_signed;
        test_div;
        test_dbz;
        test_ignored_start;
        test_back_to_back;
        test_reset_mid;
        test_early_out;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
